instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch FSM (IDLE/REQ/WAIT/HOLD) with redirect and drop handling.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to reject misaligned redirects with a fetch_err pulse.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              drop;

  logic              redir_acc;
  logic              redir_bad;
  logic [ADDR_W-1:0] redir_tgt;
  logic [ADDR_W-1:0] pc_next_seq;

`ifdef FETCH_MISALIGN_CHECK_EN
  always_comb begin
    redir_acc = redirect_valid && (redirect_pc[1:0] == 2'b00);
    redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    redir_tgt = redirect_pc;
  end
`else
  always_comb begin
    redir_acc = redirect_valid;
    redir_bad = 1'b0;
    redir_tgt = redirect_pc & ~ADDR_W'(3);
  end

  assign fetch_err = 1'b0;
`endif

  assign pc_next_seq = pc + ADDR_W'(4);

  // imem_req/imem_addr are loaded on every transition into REQ so they are
  // valid exactly during the REQ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
    end else begin
      imem_req <= 1'b0;
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (redir_acc) begin
            pc        <= redir_tgt;
            imem_addr <= redir_tgt;
          end else begin
            imem_addr <= pc;
          end
        end

        // The request already left this cycle, so a redirect here must drain
        // its response through WAIT to keep only one request in flight.
        REQ: begin
          state <= WAIT;
          if (redir_acc) begin
            pc   <= redir_tgt;
            drop <= 1'b1;
          end
        end

        WAIT: begin
          if (redir_acc) begin
            pc <= redir_tgt;
            if (imem_rvalid) begin
              drop      <= 1'b0;
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= redir_tgt;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (drop) begin
              drop      <= 1'b0;
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              state    <= HOLD;
            end
          end
        end

        HOLD: begin
          if (redir_acc) begin
            pc        <= redir_tgt;
            if_valid  <= 1'b0;
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= redir_tgt;
          end else if (if_ready) begin
            pc        <= pc_next_seq;
            if_valid  <= 1'b0;
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_next_seq;
          end
        end

        default: begin
          state    <= IDLE;
          if_valid <= 1'b0;
          drop     <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_err <= 1'b0;
    else        fetch_err <= redir_bad;
  end
`else
  logic unused_bad;
  assign unused_bad = redir_bad;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; follows FETCH_MISALIGN_CHECK_EN like the RTL.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .fetch_err(fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic applyStimulus(input logic rv, input logic [31:0] rdata,
                               input logic rdv, input logic [63:0] rpc,
                               input logic rdy);
    imem_rvalid    = rv;
    imem_rdata     = rdata;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req",   64'(imem_req),  64'h0);
    checkOutput("rst_addr",  imem_addr,      64'h0);
    checkOutput("rst_valid", 64'(if_valid),  64'h0);
    checkOutput("rst_instr", 64'(if_instr),  64'h0);
    checkOutput("rst_pc",    if_pc,          64'h0);
    checkOutput("rst_err",   64'(fetch_err), 64'h0);

    // Reset release and first fetch with a 1-cycle memory
    rst_n = 1'b1;
    #1 checkOutput("rel_req0", 64'(imem_req), 64'h0);
    applyStimulus(0, 32'h0, 0, 64'h0, 1);
    checkOutput("c2_req",  64'(imem_req), 64'h1);
    checkOutput("c2_addr", imem_addr,     64'h0);
    applyStimulus(0, 32'h0, 0, 64'h0, 1);
    checkOutput("wait_req",   64'(imem_req), 64'h0);
    checkOutput("wait_valid", 64'(if_valid), 64'h0);
    applyStimulus(1, 32'h0069_2FA3, 0, 64'h0, 1);
    checkOutput("f0_valid", 64'(if_valid), 64'h1);
    checkOutput("f0_instr", 64'(if_instr), 64'h0069_2FA3);
    checkOutput("f0_pc",    if_pc,         64'h0);
    applyStimulus(0, 32'h0, 0, 64'h0, 1);
    checkOutput("f1_req",   64'(imem_req), 64'h1);
    checkOutput("f1_addr",  imem_addr,     64'h4);
    checkOutput("f1_valid", 64'(if_valid), 64'h0);

    // Backpressure in HOLD, with a spurious strobe that must be ignored
    applyStimulus(0, 32'h0, 0, 64'h0, 0);
    applyStimulus(1, 32'h1111_1113, 0, 64'h0, 0);
    checkOutput("bp_valid0", 64'(if_valid), 64'h1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 2, 32'hFFFF_FFFF, 0, 64'h0, 0);
      checkOutput("bp_valid", 64'(if_valid), 64'h1);
      checkOutput("bp_instr", 64'(if_instr), 64'h1111_1113);
      checkOutput("bp_pc",    if_pc,         64'h4);
      checkOutput("bp_req",   64'(imem_req), 64'h0);
    end
    applyStimulus(0, 32'h0, 0, 64'h0, 1);
    checkOutput("bp_next_req",  64'(imem_req), 64'h1);
    checkOutput("bp_next_addr", imem_addr,     64'h8);

    // Redirect during WAIT: the late response is dropped
    applyStimulus(0, 32'h0, 0, 64'h0, 1);
    applyStimulus(0, 32'h0, 1, 64'h100, 1);
    checkOutput("rw_req",   64'(imem_req), 64'h0);
    checkOutput("rw_valid", 64'(if_valid), 64'h0);
    applyStimulus(0, 32'h0, 0, 64'h0, 1);
    checkOutput("rw_valid2", 64'(if_valid), 64'h0);
    applyStimulus(1, 32'hDEAD_BEEF, 0, 64'h0, 1);
    checkOutput("rw_drop_valid", 64'(if_valid), 64'h0);
    checkOutput("rw_req2",       64'(imem_req), 64'h1);
    checkOutput("rw_addr",       imem_addr,     64'h100);

    // Redirect in HOLD beats a simultaneous handshake
    applyStimulus(0, 32'h0, 0, 64'h0, 0);
    applyStimulus(1, 32'h0000_0013, 0, 64'h0, 0);
    checkOutput("rh_pc",    if_pc,         64'h100);
    checkOutput("rh_instr", 64'(if_instr), 64'h0000_0013);
    applyStimulus(0, 32'h0, 1, 64'h200, 1);
    checkOutput("rh_valid", 64'(if_valid), 64'h0);
    checkOutput("rh_req",   64'(imem_req), 64'h1);
    checkOutput("rh_addr",  imem_addr,     64'h200);

    // Redirect coinciding with the response in WAIT
    applyStimulus(0, 32'h0, 0, 64'h0, 1);
    applyStimulus(1, 32'hCAFE_0013, 1, 64'h300, 1);
    checkOutput("rc_valid", 64'(if_valid), 64'h0);
    checkOutput("rc_req",   64'(imem_req), 64'h1);
    checkOutput("rc_addr",  imem_addr,     64'h300);

    // Misaligned redirect in HOLD
    applyStimulus(0, 32'h0, 0, 64'h0, 0);
    applyStimulus(1, 32'h0000_0093, 0, 64'h0, 0);
    checkOutput("ma_pc", if_pc, 64'h300);
    applyStimulus(0, 32'h0, 1, 64'h102, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("ma_err",   64'(fetch_err), 64'h1);
    checkOutput("ma_valid", 64'(if_valid),  64'h1);
    checkOutput("ma_hpc",   if_pc,          64'h300);
    applyStimulus(0, 32'h0, 0, 64'h0, 1);
    checkOutput("ma_err_clr", 64'(fetch_err), 64'h0);
    checkOutput("ma_req",     64'(imem_req),  64'h1);
    checkOutput("ma_addr",    imem_addr,      64'h304);
`else
    checkOutput("ma_err",   64'(fetch_err), 64'h0);
    checkOutput("ma_valid", 64'(if_valid),  64'h0);
    checkOutput("ma_req",   64'(imem_req),  64'h1);
    checkOutput("ma_addr",  imem_addr,      64'h100);
`endif

    // Reset during WAIT, then a stale strobe after release
    applyStimulus(0, 32'h0, 0, 64'h0, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_valid", 64'(if_valid), 64'h0);
    checkOutput("mr_req",   64'(imem_req), 64'h0);
    checkOutput("mr_addr",  imem_addr,     64'h0);
    applyStimulus(0, 32'h0, 0, 64'h0, 1);
    rst_n = 1'b1;
    applyStimulus(1, 32'hBAD0_0BAD, 0, 64'h0, 1);
    checkOutput("mr_req2",   64'(imem_req), 64'h1);
    checkOutput("mr_addr2",  imem_addr,     64'h0);
    checkOutput("mr_valid2", 64'(if_valid), 64'h0);
    applyStimulus(1, 32'hBAD0_0BAD, 0, 64'h0, 1);
    checkOutput("mr_valid3", 64'(if_valid), 64'h0);
    applyStimulus(1, 32'h0000_0093, 0, 64'h0, 1);
    checkOutput("mr_valid4", 64'(if_valid), 64'h1);
    checkOutput("mr_instr",  64'(if_instr), 64'h0000_0093);
    checkOutput("mr_pc",     if_pc,         64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
